// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchronizer, debounce FSM and auto-repeat.
// Outputs are decoded from FSM state only, so btn_in has no combinational path to them.
module button_conditioner #(
  parameter int N_BTN      = 4,
  parameter int DBNC_CNT   = 1000000,
  parameter int REPEAT_CNT = 25000000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_rpt
);
  localparam int DW = $clog2(DBNC_CNT);
  localparam int RW = (REPEAT_CNT > 0) ? $clog2(REPEAT_CNT + 1) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DBNC_CNT - 1);
  localparam logic [RW-1:0] RLAST = RW'((REPEAT_CNT > 0) ? REPEAT_CNT - 1 : 0);
  typedef enum logic [2:0] {IDLE, WAIT_PRESS, PULSE, HELD, REPEAT, WAIT_RELEASE} state_e;
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_e        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          s, db, pl, rp;
    assign sync_d = {sync_q[0], btn_in[i]};
    assign s      = sync_q[1];
    always_ff @(posedge Clk) begin
      if (!Reset) begin
        sync_q  <= '0;
        state_q <= IDLE;
        cnt_q   <= '0;
        rpt_q   <= '0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rpt_q   <= rpt_d;
      end
    end
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rpt_d   = rpt_q;
      case (state_q)
        IDLE: if (s) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
        WAIT_PRESS: if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DLAST) state_d = PULSE;
        else cnt_d = cnt_q + 1'b1;
        PULSE: begin
          state_d = HELD;
          rpt_d   = '0;
        end
        HELD: if (!s) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end else if (REPEAT_CNT != 0 && rpt_q == RLAST) state_d = REPEAT;
        else if (REPEAT_CNT != 0) rpt_d = rpt_q + 1'b1;
        REPEAT: begin
          state_d = HELD;
          rpt_d   = '0;
        end
        WAIT_RELEASE: if (s) begin
          state_d = HELD;
          rpt_d   = '0;
        end else if (cnt_q == DLAST) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
    always_comb begin
      db = state_q inside {PULSE, HELD, REPEAT, WAIT_RELEASE};
      pl = state_q == PULSE;
      rp = state_q == PULSE || state_q == REPEAT;
    end
    assign btn_db[i]    = db;
    assign btn_pulse[i] = pl;
    assign btn_rpt[i]   = rp;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table vectors plus timed sequences against two instances
// (REPEAT_CNT=8 and REPEAT_CNT=0), expectations queued per driven cycle.
module tb_button_conditioner;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] btn_in = '0, btn_in0 = '0;
  logic [3:0] db, pl, rp, db0, pl0, rp0;
  localparam logic [3:0] Z = 4'b0000, F = 4'b1111;
  typedef struct packed {logic [3:0] db, pl, rp, db0, pl0, rp0;} exp_t;
  typedef struct packed {logic rst; logic [3:0] btn, db, pl, rp;} vec_t;
  exp_t sb[$];
  vec_t tv[$];
  int checks = 0, failures = 0;
  always #5 Clk = ~Clk;
  button_conditioner #(.N_BTN(4), .DBNC_CNT(4), .REPEAT_CNT(8)) dut (
    .Clk(Clk), .Reset(Reset), .btn_in(btn_in),
    .btn_db(db), .btn_pulse(pl), .btn_rpt(rp));
  button_conditioner #(.N_BTN(4), .DBNC_CNT(4), .REPEAT_CNT(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .btn_in(btn_in0),
    .btn_db(db0), .btn_pulse(pl0), .btn_rpt(rp0));
  function automatic exp_t mk(logic [3:0] a, b, c, d, e, f);
    mk = '{db: a, pl: b, rp: c, db0: d, pl0: e, rp0: f};
  endfunction
  task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask
  task automatic cyc(input logic r, input logic [3:0] b, input logic [3:0] b0, input exp_t e, input string t);
    exp_t x;
    Reset = r;
    btn_in = b;
    btn_in0 = b0;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    x = sb.pop_front();
    chk({t, " db"}, db, x.db);
    chk({t, " pulse"}, pl, x.pl);
    chk({t, " rpt"}, rp, x.rp);
    chk({t, " db0"}, db0, x.db0);
    chk({t, " pulse0"}, pl0, x.pl0);
    chk({t, " rpt0"}, rp0, x.rp0);
  endtask
  task automatic idle_reset();
    for (int k = 0; k < 3; k++) cyc(1'b0, Z, Z, mk(Z, Z, Z, Z, Z, Z), $sformatf("rst%0d", k));
  endtask
  initial begin
    logic [3:0] bp;
    logic [3:0] pat;
    for (int k = 0; k < 3; k++) tv.push_back('{1'b0, F, Z, Z, Z});
    for (int k = 0; k < 6; k++) tv.push_back('{1'b1, F, Z, Z, Z});
    tv.push_back('{1'b1, F, F, F, F});
    tv.push_back('{1'b1, F, F, Z, Z});
    for (int k = 0; k < 3; k++) tv.push_back('{1'b0, Z, Z, Z, Z});
    pat = 4'b0000;
    bp = 4'b0111;
    for (int k = 0; k < 12; k++) begin
      pat[0] = (k < 3) || (k == 4) || (k == 5);
      tv.push_back('{1'b1, pat, Z, Z, Z});
    end
    foreach (tv[i]) begin
      bp = (tv[i].rst && i < 11) ? F : Z;
      cyc(tv[i].rst, tv[i].btn, bp, mk(tv[i].db, tv[i].pl, tv[i].rp, tv[i].db, tv[i].pl, tv[i].rp),
          $sformatf("table%0d", i));
    end
    idle_reset();
    for (int k = 0; k < 38; k++)
      cyc(1'b1, 4'(k < 30) << 2, Z,
          mk(4'((k >= 6) && (k < 36)) << 2, 4'(k == 6) << 2, 4'(k == 6 || k == 15 || k == 24) << 2, Z, Z, Z),
          $sformatf("press%0d", k));
    idle_reset();
    for (int k = 0; k < 20; k++)
      cyc(1'b1, 4'(k < 10) << 1, Z, mk(4'((k >= 6) && (k < 16)) << 1, 4'(k == 6) << 1, 4'(k == 6) << 1, Z, Z, Z),
          $sformatf("release%0d", k));
    idle_reset();
    for (int k = 0; k < 24; k++)
      cyc(1'b1, 4'(k < 10 || k == 12 || k == 13) << 1, Z,
          mk(4'((k >= 6) && (k < 20)) << 1, 4'(k == 6) << 1, 4'(k == 6) << 1, Z, Z, Z),
          $sformatf("glitch%0d", k));
    idle_reset();
    for (int k = 0; k < 110; k++)
      cyc(1'b1, Z, 4'(k < 100) << 3,
          mk(Z, Z, Z, 4'((k >= 6) && (k < 106)) << 3, 4'(k == 6) << 3, 4'(k == 6) << 3),
          $sformatf("norpt%0d", k));
    idle_reset();
    for (int k = 0; k < 23; k++) begin
      exp_t e;
      int j;
      j = k - 12;
      if (k < 10) e = mk({2'b0, k >= 8, k >= 6}, {2'b0, k == 8, k == 6}, {2'b0, k == 8, k == 6}, Z, Z, Z);
      else if (k < 12) e = mk(Z, Z, Z, Z, Z, Z);
      else e = mk({2'b0, {2{j >= 6}}}, {2'b0, {2{j == 6}}}, {2'b0, {2{j == 6}}}, Z, Z, Z);
      cyc(!(k == 10 || k == 11), {2'b0, k >= 2, 1'b1}, Z, e, $sformatf("indep%0d", k));
    end
    idle_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
